// File: rtl/alu_pkg.sv
// Shared constants for the shared-ALU arbiter: op codes, requester IDs, default width.
package alu_pkg;

    localparam int DEF_N = 32;

    typedef logic [2:0] opCode_t;

    localparam opCode_t OP_ADD  = 3'b000;
    localparam opCode_t OP_SUB  = 3'b001;
    localparam opCode_t OP_AND  = 3'b010;
    localparam opCode_t OP_OR   = 3'b011;
    localparam opCode_t OP_ILL  = 3'b100;
    localparam opCode_t OP_SLL  = 3'b101;
    localparam opCode_t OP_SLTU = 3'b110;
    localparam opCode_t OP_XOR  = 3'b111;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_share_exec.sv
// Purely combinational integer ALU shared by both requesters; flags zero results and the illegal op.
module alu_share_exec
    import alu_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  opCode_t      op,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         illegal
);

    localparam int SH_W = $clog2(N);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_SLL:  result = a << b[SH_W-1:0];
            OP_SLTU: result = {{(N-1){1'b0}}, (a < b)};
            OP_XOR:  result = a ^ b;
            default: illegal = 1'b1;
        endcase
        // illegal ops report data=0 but never claim a zero result
        zero = !illegal && (result == '0);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters with a one-entry result buffer.
// Optional grant/conflict statistics counters are enabled by defining ALU_SHARE_ARB_STATS_EN.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N = DEF_N
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_id,
    output logic         rsp_illegal
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    logic         canAccept;
    logic         bothValid;
    logic         grantValid;
    logic         grantId;
    logic         lastGrant;
    logic [N-1:0] execA;
    logic [N-1:0] execB;
    opCode_t      execOp;
    logic [N-1:0] execResult;
    logic         execZero;
    logic         execIllegal;

    always_comb begin
        canAccept  = !rsp_valid || rsp_ready;
        bothValid  = req0_valid && req1_valid;
        grantValid = canAccept && (req0_valid || req1_valid);
        // on conflict the requester that did not win last time goes first
        grantId    = bothValid ? !lastGrant : req1_valid;
        req0_ready = grantValid && (grantId == REQ0);
        req1_ready = grantValid && (grantId == REQ1);
        execA      = (grantId == REQ1) ? req1_a  : req0_a;
        execB      = (grantId == REQ1) ? req1_b  : req0_b;
        execOp     = (grantId == REQ1) ? req1_op : req0_op;
    end

    alu_share_exec #(
        .N(N)
    ) uExec (
        .a       (execA),
        .b       (execB),
        .op      (execOp),
        .result  (execResult),
        .zero    (execZero),
        .illegal (execIllegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_zero    <= 1'b0;
            rsp_id      <= REQ0;
            rsp_illegal <= 1'b0;
            lastGrant   <= REQ1;
        end else if (grantValid) begin
            rsp_valid   <= 1'b1;
            rsp_data    <= execResult;
            rsp_zero    <= execZero;
            rsp_id      <= grantId;
            rsp_illegal <= execIllegal;
            lastGrant   <= grantId;
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

`ifdef ALU_SHARE_ARB_STATS_EN
    // counters saturate at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_cnt   <= '0;
            grant1_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (req0_ready && (grant0_cnt != '1))
                grant0_cnt <= grant0_cnt + 1'b1;
            if (req1_ready && (grant1_cnt != '1))
                grant1_cnt <= grant1_cnt + 1'b1;
            if (bothValid && grantValid && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule
